// File: rtl/rs232_pkg.sv
// ============================================================================
// Package : rs232_pkg
// Brief   : Shared RS232 constants, receiver state encoding, tick helper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rs232_pkg;

  // Last tick index of a bit period; common to transmitter and receiver.
  localparam int FAST_LIMIT = 217;
  localparam int SLOW_LIMIT = 1302;
  localparam int DATA_BITS  = 8;
  localparam int TICK_W     = 12;
  localparam int BITCNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic logic [TICK_W-1:0] half_period(input logic [TICK_W-1:0] limit);
    return limit >> 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs232_rx_if.sv
// ============================================================================
// Interface : rs232_rx_if
// Brief     : Host-side byte handshake of the receiver (data/rdy/done + flags).
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface rs232_rx_if;
  import rs232_pkg::*;

  logic                 done;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 ovr;
  logic                 ferr;

  modport master (output done, input data, rdy, ovr, ferr);
  modport slave  (input done, output data, rdy, ovr, ferr);
endinterface

`default_nettype wire

// File: rtl/rs232_sync.sv
// ============================================================================
// Module : rs232_sync
// Brief  : Two-flop synchronizer for the idle-high serial line.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rs232_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Reset to 1 so a receiver leaving reset sees an idle line, not a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/rs232_rx.sv
// ============================================================================
// Module : rs232_rx
// Brief  : 8N1 LSB-first receiver, mid-bit sampling; RS232_RX_FERR_EN adds
//          a sticky framing-error flag and discards badly framed bytes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rs232_rx #(
  parameter int FAST_LIMIT = rs232_pkg::FAST_LIMIT,
  parameter int SLOW_LIMIT = rs232_pkg::SLOW_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fsel,
  input  logic       RxD,
  rs232_rx_if.slave  host
);
  import rs232_pkg::*;

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [TICK_W-1:0]    limit_q, limit_d;
  logic [TICK_W-1:0]    half;
  logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;
`ifdef RS232_RX_FERR_EN
  logic                 ferr_q, ferr_d;
  logic                 bad_stop;
`endif

  rs232_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxs)
  );

  assign half = half_period(limit_q);

  always_comb begin
    state_d  = state_q;
    tick_d   = (tick_q == limit_q) ? '0 : tick_q + 1'b1;
    limit_d  = limit_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
`ifdef RS232_RX_FERR_EN
    bad_stop = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          limit_d = fsel ? TICK_W'(FAST_LIMIT) : TICK_W'(SLOW_LIMIT);
        end
      end
      START: begin
        if (tick_q == half) begin
          state_d  = rxs ? IDLE : DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (tick_q == limit_q) begin
          shreg_d  = {rxs, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BITCNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick_q == limit_q) begin
          if (rxs) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
`ifdef RS232_RX_FERR_EN
            bad_stop = 1'b1;
`else
            deliver  = 1'b1;
`endif
            // A held-low line must not look like the next start bit.
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      tick_d = '0;
    end
  end

  // Delivery outranks a coincident done: the new byte stays flagged and the
  // acknowledge suppresses the overrun it would otherwise cause.
  always_comb begin
    data_d = deliver ? shreg_q : data_q;
    rdy_d  = deliver | (rdy_q & ~host.done);
    ovr_d  = ~host.done & (ovr_q | (deliver & rdy_q));
`ifdef RS232_RX_FERR_EN
    ferr_d = bad_stop | (ferr_q & ~host.done);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      limit_q  <= TICK_W'(SLOW_LIMIT);
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef RS232_RX_FERR_EN
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      limit_q  <= limit_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ovr_q    <= ovr_d;
`ifdef RS232_RX_FERR_EN
      ferr_q   <= ferr_d;
`endif
    end
  end

  assign host.data = data_q;
  assign host.rdy  = rdy_q;
  assign host.ovr  = ovr_q;
`ifdef RS232_RX_FERR_EN
  assign host.ferr = ferr_q;
`else
  assign host.ferr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs232_rx.sv
// ============================================================================
// Module : tb_rs232_rx
// Brief  : Self-checking bench for rs232_rx against a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rs232_rx;
  localparam int FAST_P = 218;
  localparam int SLOW_P = 1303;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsel = 1'b1;
  logic rxd = 1'b1;

  rs232_rx_if bus ();

  rs232_rx dut (
    .clk  (clk),
    .rst  (rst),
    .fsel (fsel),
    .RxD  (rxd),
    .host (bus)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  // Frame-level model: what the host port must show once a frame has ended.
  logic [7:0] m_data = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  bit         quiet  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (quiet) begin
        checks++;
        if ({bus.rdy, bus.ovr, bus.ferr, bus.data} !== {m_rdy, m_ovr, m_ferr, m_data}) begin
          errors++;
          $display("FAIL cycle_cmp cyc=%0d actual rdy=%b ovr=%b ferr=%b data=%h required rdy=%b ovr=%b ferr=%b data=%h",
                   cyc_n, bus.rdy, bus.ovr, bus.ferr, bus.data, m_rdy, m_ovr, m_ferr, m_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stop_ok, input bit coinc);
`ifdef RS232_RX_FERR_EN
    if (!stop_ok) begin
      m_ferr = 1'b1;
      return;
    end
`endif
    if (coinc) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (m_rdy) begin
      m_ovr = 1'b1;
    end
    m_rdy  = 1'b1;
    m_data = b;
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    wait_cycles(1);
    bus.done = 1'b0;
    m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Drives one frame with the given bit period; fsel may wander mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int period,
                            input int hold, input bit randf, input bit coinc);
    rxd = 1'b0;
    wait_cycles(period);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (randf) begin
        wait_cycles(period / 2);
        fsel = 1'($urandom);
        wait_cycles(period - period / 2);
      end else begin
        wait_cycles(period);
      end
    end
    rxd   = stop_v;
    quiet = 1'b0;
    wait_cycles(period);
    m_frame(b, stop_v, coinc);
    quiet = 1'b1;
    if (hold > 0) wait_cycles(hold);
    rxd = 1'b1;
    wait_cycles(12);
  endtask

  initial begin
    int s0;
    int d_edge;
    int off;
    int target;
    bus.done = 1'b0;

    // Reset
    wait_cycles(5);
    @(negedge clk);
    chk("rst_rdy",  32'(bus.rdy),  32'h0);
    chk("rst_ovr",  32'(bus.ovr),  32'h0);
    chk("rst_ferr", 32'(bus.ferr), 32'h0);
    chk("rst_data", 32'(bus.data), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    wait_cycles(4);
    quiet = 1'b1;

    // Single fast byte, then acknowledge
    fsel = 1'b1;
    send_frame(8'hA5, 1'b1, FAST_P, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_data", 32'(bus.data), 32'hA5);
    chk("t1_rdy",  32'(bus.rdy),  32'h1);
    chk("t1_ovr",  32'(bus.ovr),  32'h0);
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    chk("t1_rdy_after_done", 32'(bus.rdy), 32'h0);
    @(posedge clk); #1;

    // Slow back-to-back bytes, second one 2% fast
    fsel = 1'b0;
    send_frame(8'h00, 1'b1, SLOW_P, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_data0", 32'(bus.data), 32'h00);
    chk("t2_rdy0",  32'(bus.rdy),  32'h1);
    @(posedge clk); #1;
    pulse_done();
    send_frame(8'hFF, 1'b1, SLOW_P - 26, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_data1", 32'(bus.data), 32'hFF);
    chk("t2_ovr1",  32'(bus.ovr),  32'h0);
    @(posedge clk); #1;
    pulse_done();

    // Overrun: second byte (2% slow) without acknowledge
    fsel = 1'b1;
    send_frame(8'h3C, 1'b1, FAST_P, 0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, FAST_P + 4, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_data", 32'(bus.data), 32'hC3);
    chk("t3_rdy",  32'(bus.rdy),  32'h1);
    chk("t3_ovr",  32'(bus.ovr),  32'h1);
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    chk("t3_rdy_cleared", 32'(bus.rdy), 32'h0);
    chk("t3_ovr_cleared", 32'(bus.ovr), 32'h0);
    @(posedge clk); #1;

    // Short glitch is rejected
    rxd = 1'b0;
    wait_cycles(50);
    rxd = 1'b1;
    wait_cycles(500);
    @(negedge clk);
    chk("t4_rdy", 32'(bus.rdy), 32'h0);
    @(posedge clk); #1;

    // Bad stop bit with a long break, 2% fast
    send_frame(8'h55, 1'b0, FAST_P - 4, 5000, 1'b0, 1'b0);
    wait_cycles(2000);
    @(negedge clk);
`ifdef RS232_RX_FERR_EN
    chk("t5_ferr", 32'(bus.ferr), 32'h1);
    chk("t5_rdy",  32'(bus.rdy),  32'h0);
`else
    chk("t5_rdy",  32'(bus.rdy),  32'h1);
    chk("t5_data", 32'(bus.data), 32'h55);
    chk("t5_ovr",  32'(bus.ovr),  32'h0);
`endif
    @(posedge clk); #1;
    pulse_done();

    // Reset during bit 4 of a frame while an earlier byte is pending
    send_frame(8'h7E, 1'b1, FAST_P, 0, 1'b0, 1'b0);
    rxd = 1'b0;
    wait_cycles(FAST_P);
    for (int i = 0; i < 4; i++) begin
      rxd = (i % 2 == 0);
      wait_cycles(FAST_P);
    end
    rxd = 1'b1;
    wait_cycles(FAST_P / 2);
    quiet = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    chk("t6_rst_rdy",  32'(bus.rdy),  32'h0);
    chk("t6_rst_data", 32'(bus.data), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    wait_cycles(4);
    quiet = 1'b1;
    send_frame(8'h81, 1'b1, FAST_P + 2, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_data", 32'(bus.data), 32'h81);
    chk("t6_rdy",  32'(bus.rdy),  32'h1);
    chk("t6_ovr",  32'(bus.ovr),  32'h0);
    @(posedge clk); #1;
    pulse_done();

    // Find the delivery edge of a nominal fast frame, then land done on it
    s0 = cyc_n;
    d_edge = -1;
    fork
      send_frame(8'h12, 1'b1, FAST_P, 0, 1'b0, 1'b0);
      begin
        for (int k = 0; k < 3 * 11 * FAST_P && d_edge < 0; k++) begin
          @(negedge clk);
          if (bus.rdy === 1'b1) d_edge = cyc_n;
        end
      end
    join
    if (d_edge < 0) begin
      checks++;
      errors++;
      $display("FAIL t7_deliver_timeout actual=none required=rdy within %0d cycles", 3 * 11 * FAST_P);
      off = 4 + (FAST_P - 1) / 2 + 9 * FAST_P;
    end else begin
      off = d_edge - s0;
      // Mid stop bit is 9.5 bit periods in; allow synchronizer plus rounding.
      checks++;
      if (off < 9 * FAST_P + FAST_P / 2 - 2 || off > 9 * FAST_P + FAST_P / 2 + 6) begin
        errors++;
        $display("FAIL t7_deliver_latency actual=%0d required=%0d..%0d", off,
                 9 * FAST_P + FAST_P / 2 - 2, 9 * FAST_P + FAST_P / 2 + 6);
      end
    end
    target = cyc_n + off - 1;
    fork
      send_frame(8'h34, 1'b1, FAST_P, 0, 1'b0, 1'b1);
      begin
        while (cyc_n < target) begin
          @(posedge clk); #1;
        end
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
      end
    join
    @(negedge clk);
    chk("t7_rdy",  32'(bus.rdy),  32'h1);
    chk("t7_data", 32'(bus.data), 32'h34);
    chk("t7_ovr",  32'(bus.ovr),  32'h0);
    @(posedge clk); #1;
    pulse_done();

    // Random bytes, random +-2% skew, fsel wandering mid-frame, random acks
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      int p;
      b = 8'($urandom);
      p = FAST_P + int'($urandom_range(0, 8)) - 4;
      fsel = 1'b1;
      send_frame(b, 1'b1, p, 0, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_done();
    end
    fsel = 1'b1;
    pulse_done();
    wait_cycles(20);

    quiet = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
